dm_lsu: RTL and testbench
=========================

# dm_lsu

Parametrised data memory with an integrated load/store unit for the pipelined CPU's MEM stage. It supports word, half and byte accesses with signed or unsigned load extension and byte-lane stores. It detects misaligned, out-of-range and illegal-op requests and flags them as errors without touching memory. Reads are synchronous, so the array can be inferred as block RAM, and a counter-driven sweep clears the memory after reset.

## Interface
- `DEPTH`, default 4096: memory size in 32-bit words; power of two, at least 4.
- `CLEAR_ON_RESET`, default 1: when 1, a zero-fill sweep runs after reset; when 0, the block enters IDLE directly.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; asserting it (0) immediately forces the reset state.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_op` in 3: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101–111 illegal. For stores, 001 and 010 both mean half, 011 and 100 both mean byte.
- `req_addr` in 32: byte address.
- `req_wd` in 32: store data; the low 16 or 8 bits are used for half and byte stores.
- `rsp_valid` out 1: one-cycle pulse, one per accepted request.
- `rsp_rd` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: qualified by `rsp_valid`; misaligned, out-of-range or illegal op.
- `busy` out 1: clear sweep in progress.

## Operation
- Two states:
  - CLEAR: `busy`=1, `req_ready`=0. An index counter writes 0 to word[idx] each cycle, idx from 0 to DEPTH-1. After writing word[DEPTH-1] the block moves to IDLE.
  - IDLE: `busy`=0, `req_ready`=1 every cycle.
- Accept: `req_valid` && `req_ready` at a rising edge.
- Word index is `req_addr[log2(DEPTH)+1:2]`. Byte lane k is bits [8k+7:8k], with k = `req_addr[1:0]`.
- Error checks are evaluated at accept:
  - misaligned: word with `addr[1:0]` ≠ 0, or half with `addr[0]` ≠ 0;
  - out of range: `req_addr` ≥ 4·DEPTH;
  - illegal: `req_op` in 101–111, for both loads and stores.
- On error: no memory write, `rsp_err`=1, `rsp_rd`=0.
- Stores write only the addressed lanes:
  - word: all 4 lanes;
  - half: lanes k and k+1 take `req_wd[15:0]`, little-endian;
  - byte: lane k takes `req_wd[7:0]`;
  - all other lanes are unchanged.
- Loads:
  - word: returns the whole word;
  - half: returns lanes k and k+1, sign- or zero-extended to 32 bits;
  - byte: returns lane k, sign- or zero-extended.
- Load data is computed from the registered read word and the registered op/lane, so no combinational path from `req_addr` to `rsp_rd` through the array.

## Timing
- Reset values while `reset`=0 and at its deassertion:
  - `rsp_valid`=0, `rsp_rd`=0, `rsp_err`=0, idx=0;
  - state = CLEAR and `busy`=1 if CLEAR_ON_RESET, else IDLE and `busy`=0;
  - `req_ready` = !`busy`.
- The array itself is not asynchronously reset.
- Clear sweep: DEPTH cycles from the first edge after deassertion. The first request can be accepted at edge DEPTH+1.
- Latency is 1: a request accepted at edge N gives `rsp_valid`=1 with data/err during cycle N to N+1.
- `rsp_valid` is low in any cycle with no accept on the preceding edge.
- Throughput is 1 request per cycle in IDLE.
- A store writes memory at its accept edge, so a load accepted on the next edge returns the new data (back-to-back RAW is correct).
- Reset asserted mid-sweep restarts the sweep from idx 0.
- Reset asserted with a response pending drops that response; `rsp_valid` goes to 0 immediately.
- A store in flight at reset may or may not have committed; the sweep zeroes it anyway.
- `req_*` are ignored while `req_ready`=0, and nothing is queued.

## Test plan
- Reset with DEPTH=16, CLEAR_ON_RESET=1 -> `busy`=1 and `req_ready`=0 for exactly 16 cycles; then lw 0x3C -> `rsp_rd`=0, `rsp_err`=0.
- sw 0x12345678 @0x10, then:
  - lw 0x10 -> 0x12345678;
  - lb 0x11 -> 0x00000056;
  - lbu 0x13 -> 0x00000012;
  - lhu 0x12 -> 0x00001234.
- sw 0 @0x20, sb 0x80 @0x20, sh 0x8001 @0x22, then:
  - lw 0x20 -> 0x80010080;
  - lb 0x20 -> 0xFFFFFF80;
  - lh 0x22 -> 0xFFFF8001.
- Error cases, each returning `rsp_err`=1, `rsp_rd`=0:
  - lw 0x21 and sh 0x23: memory at 0x20 unchanged;
  - DEPTH=16, sw 0x40: no write;
  - op 101 load.
- Back-to-back on consecutive edges: sw 0xAAAA5555 @0x8 then lw @0x8 -> 0xAAAA5555, with `rsp_valid` high in both cycles.
- Assert `reset` at sweep cycle 7 of 16 -> `busy` stays 1 and the full 16-cycle sweep restarts; previously stored words read 0 afterwards.

Source files
------------

// File: rtl/dm_lsu.sv
// Data memory with an integrated load/store unit for the MEM stage.
// Synchronous-read word array, byte-lane stores, extended loads, zero-fill sweep after reset.
module dm_lsu #(
   parameter int unsigned DEPTH          = 4096,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wd,
   output logic        rsp_valid,
   output logic [31:0] rsp_rd,
   output logic        rsp_err,
   output logic        busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

   typedef enum logic {StClear, StIdle} state_t;

   state_t        state_q;
   logic [AW-1:0] idx_q;
   logic          rsp_valid_q, rsp_err_q, rsp_we_q;
   logic [2:0]    rsp_op_q;
   logic [1:0]    rsp_lane_q;
   logic [31:0]   rd_word_q;
   logic [31:0]   mem [DEPTH];

   logic          accept, req_err, is_word, is_half;
   logic [1:0]    lane;
   logic [AW-1:0] widx;
   logic          wr_en;
   logic [AW-1:0] wr_idx;
   logic [3:0]    wr_be;
   logic [31:0]   wr_data;
   logic [7:0]    sel_byte;
   logic [15:0]   sel_half;
   logic [31:0]   ld_data;

   assign busy      = (state_q == StClear);
   assign req_ready = !busy;
   assign accept    = req_valid && req_ready;
   assign lane      = req_addr[1:0];
   assign widx      = req_addr[AW+1:2];
   assign is_word   = (req_op == 3'd0);
   assign is_half   = (req_op == 3'd1) || (req_op == 3'd2);
   assign req_err   = (req_op > 3'd4)
                    || (is_word && (lane != 2'd0))
                    || (is_half && lane[0])
                    || ((req_addr >> (AW + 2)) != 32'd0);

   // Sweep owns the write port while clearing; otherwise only error-free stores write.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = idx_q;
      wr_be   = 4'b1111;
      wr_data = 32'd0;
      if (state_q == StClear) begin
         wr_en = 1'b1;
      end else if (accept && req_we && !req_err) begin
         wr_en  = 1'b1;
         wr_idx = widx;
         case (req_op)
            3'd0: begin
               wr_be   = 4'b1111;
               wr_data = req_wd;
            end
            3'd1, 3'd2: begin
               wr_be   = lane[1] ? 4'b1100 : 4'b0011;
               wr_data = {2{req_wd[15:0]}};
            end
            default: begin
               wr_be   = 4'b0001 << lane;
               wr_data = {4{req_wd[7:0]}};
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
      if (accept && !req_we) rd_word_q <= mem[widx];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= CLEAR_ON_RESET ? StClear : StIdle;
         idx_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_op_q    <= 3'd0;
         rsp_lane_q  <= 2'd0;
      end else begin
         rsp_valid_q <= accept;
         if (accept) begin
            rsp_err_q  <= req_err;
            rsp_we_q   <= req_we;
            rsp_op_q   <= req_op;
            rsp_lane_q <= lane;
         end
         case (state_q)
            StClear: begin
               idx_q <= idx_q + 1'b1;
               if (idx_q == LastIdx) state_q <= StIdle;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      sel_byte = rd_word_q[{rsp_lane_q, 3'b000} +: 8];
      sel_half = rsp_lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
      case (rsp_op_q)
         3'd0:    ld_data = rd_word_q;
         3'd1:    ld_data = {{16{sel_half[15]}}, sel_half};
         3'd2:    ld_data = {16'd0, sel_half};
         3'd3:    ld_data = {{24{sel_byte[7]}}, sel_byte};
         default: ld_data = {24'd0, sel_byte};
      endcase
      rsp_rd = (rsp_valid_q && !rsp_err_q && !rsp_we_q) ? ld_data : 32'd0;
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_valid_q && rsp_err_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Scoreboard bench for dm_lsu (DEPTH=16): expected responses queued at drive, popped on rsp_valid.
module tb_dm_lsu;

   localparam logic [2:0] OpW = 3'd0, OpH = 3'd1, OpHu = 3'd2, OpB = 3'd3, OpBu = 3'd4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_op = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wd = 32'd0;
   logic        rsp_valid;
   logic [31:0] rsp_rd;
   logic        rsp_err;
   logic        busy;

   int          errors = 0;
   int          checks = 0;
   logic [32:0] exp_q[$];
   string       tag_q[$];

   dm_lsu #(.DEPTH(16), .CLEAR_ON_RESET(1'b1)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_wd    (req_wd),
      .rsp_valid (rsp_valid),
      .rsp_rd    (rsp_rd),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Responses are registered, so sampling on the falling edge is race-free.
   always @(negedge clk) begin
      if (reset && rsp_valid) begin
         if (exp_q.size() == 0) begin
            check("spurious_rsp", {31'd0, rsp_valid}, 32'd0);
         end else begin
            logic [32:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, "_rd"}, rsp_rd, e[31:0]);
            check({t, "_err"}, {31'd0, rsp_err}, {31'd0, e[32]});
         end
      end
   end

   task automatic send(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input string tag);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         check({tag, "_ready"}, 32'd0, 32'd1);
         return;
      end
      req_valid = 1'b1;
      req_we    = we;
      req_op    = op;
      req_addr  = addr;
      req_wd    = wd;
      exp_q.push_back({exp_err, exp_rd});
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check({tag, "_vld"}, {31'd0, rsp_valid}, 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_q.size(), 32'd0);
   endtask

   task automatic sweep_len(input string tag);
      int n = 0;
      while (busy && n < 100) begin
         n++;
         @(posedge clk);
         #1;
      end
      check(tag, n, 32'd16);
      check({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd1);
      check("rst_ready", {31'd0, req_ready}, 32'd0);
      check("rst_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rd", rsp_rd, 32'd0);
      check("rst_err", {31'd0, rsp_err}, 32'd0);
      reset = 1'b1;
      sweep_len("sweep_len");

      send(1'b0, OpW, 32'h3C, 32'd0, 32'd0, 1'b0, "lw_3c");

      send(1'b1, OpW, 32'h10, 32'h12345678, 32'd0, 1'b0, "sw_10");
      send(1'b0, OpW, 32'h10, 32'd0, 32'h12345678, 1'b0, "lw_10");
      send(1'b0, OpB, 32'h11, 32'd0, 32'h00000056, 1'b0, "lb_11");
      send(1'b0, OpBu, 32'h13, 32'd0, 32'h00000012, 1'b0, "lbu_13");
      send(1'b0, OpHu, 32'h12, 32'd0, 32'h00001234, 1'b0, "lhu_12");

      send(1'b1, OpW, 32'h20, 32'd0, 32'd0, 1'b0, "sw_20");
      send(1'b1, OpB, 32'h20, 32'hFFFFFF80, 32'd0, 1'b0, "sb_20");
      send(1'b1, OpHu, 32'h22, 32'hABCD8001, 32'd0, 1'b0, "sh_22");
      send(1'b0, OpW, 32'h20, 32'd0, 32'h80010080, 1'b0, "lw_20");
      send(1'b0, OpB, 32'h20, 32'd0, 32'hFFFFFF80, 1'b0, "lb_20");
      send(1'b0, OpH, 32'h22, 32'd0, 32'hFFFF8001, 1'b0, "lh_22");
      send(1'b0, OpHu, 32'h20, 32'd0, 32'h00000080, 1'b0, "lhu_20");
      send(1'b0, OpBu, 32'h23, 32'd0, 32'h00000080, 1'b0, "lbu_23");

      send(1'b0, OpW, 32'h21, 32'd0, 32'd0, 1'b1, "lw_mis");
      send(1'b1, OpH, 32'h23, 32'h0000FFFF, 32'd0, 1'b1, "sh_mis");
      send(1'b0, OpW, 32'h20, 32'd0, 32'h80010080, 1'b0, "lw_20_keep");
      send(1'b1, OpW, 32'h40, 32'hDEADBEEF, 32'd0, 1'b1, "sw_oor");
      send(1'b0, OpW, 32'h00, 32'd0, 32'd0, 1'b0, "lw_00_keep");
      send(1'b0, 3'd5, 32'h10, 32'd0, 32'd0, 1'b1, "ld_op5");
      send(1'b1, 3'd7, 32'h04, 32'hFFFFFFFF, 32'd0, 1'b1, "st_op7");
      send(1'b0, OpW, 32'h04, 32'd0, 32'd0, 1'b0, "lw_04_keep");

      send(1'b1, OpW, 32'h08, 32'hAAAA5555, 32'd0, 1'b0, "b2b_sw");
      send(1'b0, OpW, 32'h08, 32'd0, 32'hAAAA5555, 1'b0, "b2b_lw");
      drain();
      @(negedge clk);
      check("idle_no_rsp", {31'd0, rsp_valid}, 32'd0);

      // Reset with a response pending, then a second reset in the middle of the sweep.
      send(1'b0, OpW, 32'h10, 32'd0, 32'h12345678, 1'b0, "lw_pend");
      reset = 1'b0;
      #1;
      check("pend_drop", {31'd0, rsp_valid}, 32'd0);
      check("pend_busy", {31'd0, busy}, 32'd1);
      exp_q.delete();
      tag_q.delete();
      @(negedge clk);
      reset = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      check("mid_busy", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      sweep_len("resweep_len");
      send(1'b0, OpW, 32'h10, 32'd0, 32'd0, 1'b0, "clr_10");
      send(1'b0, OpW, 32'h20, 32'd0, 32'd0, 1'b0, "clr_20");
      send(1'b0, OpW, 32'h08, 32'd0, 32'd0, 1'b0, "clr_08");
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
